// File: rtl/encoder_core_mc_if.sv
// Bus bundle between the encoder core and the register block: control
// inputs, raw encoder pins and the register-readable channel status.
interface encoder_core_mc_if #(
  parameter int NUM_CH = 4,
  parameter int POS_W  = 32,
  parameter int VEL_W  = 16
);
  logic                      enable;
  logic [1:0]                mode;
  logic [NUM_CH-1:0]         idx_clr_en;
  logic [NUM_CH-1:0]         err_clr;
  logic [NUM_CH-1:0]         enc_a;
  logic [NUM_CH-1:0]         enc_b;
  logic [NUM_CH-1:0]         enc_z;
  logic [NUM_CH*POS_W-1:0]   position;
  logic [NUM_CH*VEL_W-1:0]   velocity;
  logic                      vel_valid;
  logic [NUM_CH-1:0]         direction;
  logic [NUM_CH-1:0]         idx_seen;
  logic [NUM_CH-1:0]         err;

  modport master (
    output enable, mode, idx_clr_en, err_clr, enc_a, enc_b, enc_z,
    input  position, velocity, vel_valid, direction, idx_seen, err
  );

  modport slave (
    input  enable, mode, idx_clr_en, err_clr, enc_a, enc_b, enc_z,
    output position, velocity, vel_valid, direction, idx_seen, err
  );
endinterface

// File: rtl/encoder_core_mc.sv
// Multi-channel quadrature encoder core: sync + glitch filter + x1/x2/x4
// decode, wrapping position, index zeroing, error flag, windowed velocity.
module encoder_core_mc #(
  parameter int NUM_CH        = 4,
  parameter int POS_W         = 32,
  parameter int VEL_W         = 16,
  parameter int WINDOW_CYCLES = 100_000_000,
  parameter int FILT_LEN      = 4
) (
  input logic              clk,
  input logic              reset,
  encoder_core_mc_if.slave bus
);
  localparam int IN_W  = 3 * NUM_CH;
  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TMR_W = $clog2(WINDOW_CYCLES);

  logic [IN_W-1:0]         sync_p0, sync_p1, filt_p2, filt_p3;
  logic [CNT_W-1:0]        fcnt_p2 [IN_W];
  logic [TMR_W-1:0]        timer;
  logic signed [POS_W-1:0] pos_r [NUM_CH];
  logic signed [VEL_W-1:0] acc_r [NUM_CH];
  logic signed [VEL_W-1:0] vel_r [NUM_CH];
  logic [NUM_CH-1:0]       dir_r, seen_r, err_r;
  logic                    vld_p3;
  logic [1:0]              ab_prev [NUM_CH];
  logic [1:0]              ab_curr [NUM_CH];
  logic signed [1:0]       step [NUM_CH];
  logic [NUM_CH-1:0]       illegal, z_rise;
  logic                    win_end;

  // {a,b} prev->curr; modes 00 and 11 both select x4.
  function automatic logic signed [1:0] decode_step(input logic [1:0] prev,
                                                    input logic [1:0] curr,
                                                    input logic [1:0] md);
    logic x4, x1;
    logic signed [1:0] s;
    x4 = (md[1] == md[0]);
    x1 = (md == 2'b10);
    s  = 2'sb00;
    case ({prev, curr})
      4'b00_01, 4'b11_10: s = x4 ? 2'sb01 : 2'sb00;
      4'b01_00, 4'b10_11: s = x4 ? 2'sb11 : 2'sb00;
      4'b10_00:           s = x1 ? 2'sb00 : 2'sb01;
      4'b00_10:           s = x1 ? 2'sb00 : 2'sb11;
      4'b01_11:           s = 2'sb01;
      4'b11_01:           s = 2'sb11;
      default:            s = 2'sb00;
    endcase
    return s;
  endfunction

  function automatic logic is_illegal(input logic [1:0] prev, input logic [1:0] curr);
    return (prev ^ curr) == 2'b11;
  endfunction

  function automatic logic signed [VEL_W-1:0] sat_add(input logic signed [VEL_W-1:0] acc,
                                                      input logic signed [1:0] st);
    logic [VEL_W:0] sum;
    sum = {acc[VEL_W-1], acc} + {{(VEL_W-1){st[1]}}, st};
    if (sum[VEL_W] != sum[VEL_W-1])
      return sum[VEL_W] ? {1'b1, {(VEL_W-1){1'b0}}} : {1'b0, {(VEL_W-1){1'b1}}};
    return sum[VEL_W-1:0];
  endfunction

  // Stage p3: decode filtered levels against the previous filtered levels
  always_comb begin
    win_end = bus.enable && (timer == TMR_W'(WINDOW_CYCLES - 1));
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ab_prev[ch] = {filt_p3[ch], filt_p3[NUM_CH+ch]};
      ab_curr[ch] = {filt_p2[ch], filt_p2[NUM_CH+ch]};
      illegal[ch] = is_illegal(ab_prev[ch], ab_curr[ch]);
      step[ch]    = decode_step(ab_prev[ch], ab_curr[ch], bus.mode);
      z_rise[ch]  = filt_p2[2*NUM_CH+ch] & ~filt_p3[2*NUM_CH+ch];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      filt_p2 <= '0;
      filt_p3 <= '0;
      timer   <= '0;
      vld_p3  <= 1'b0;
      dir_r   <= '0;
      seen_r  <= '0;
      err_r   <= '0;
      for (int i = 0; i < IN_W; i++) fcnt_p2[i] <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        pos_r[ch] <= '0;
        acc_r[ch] <= '0;
        vel_r[ch] <= '0;
      end
    end else begin
      // Stage p0/p1: two-flop synchroniser, a/b/z packed side by side
      sync_p0 <= {bus.enc_z, bus.enc_b, bus.enc_a};
      sync_p1 <= sync_p0;
      // Stage p2: a level is accepted on its FILT_LEN-th consecutive sample
      for (int i = 0; i < IN_W; i++) begin
        if (sync_p1[i] == filt_p2[i]) begin
          fcnt_p2[i] <= '0;
        end else if (fcnt_p2[i] == CNT_W'(FILT_LEN - 1)) begin
          filt_p2[i] <= sync_p1[i];
          fcnt_p2[i] <= '0;
        end else begin
          fcnt_p2[i] <= fcnt_p2[i] + 1'b1;
        end
      end
      filt_p3 <= filt_p2;
      // Stage p3: per-channel state update
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (illegal[ch])
          err_r[ch] <= 1'b1;
        else if (bus.err_clr[ch])
          err_r[ch] <= 1'b0;
        if (z_rise[ch])
          seen_r[ch] <= 1'b1;
        if (bus.enable) begin
          if (z_rise[ch] && bus.idx_clr_en[ch])
            pos_r[ch] <= '0;
          else
            pos_r[ch] <= pos_r[ch] + {{(POS_W-2){step[ch][1]}}, step[ch]};
          if (step[ch] != 2'sb00)
            dir_r[ch] <= ~step[ch][1];
          if (win_end) begin
            vel_r[ch] <= sat_add(acc_r[ch], step[ch]);
            acc_r[ch] <= '0;
          end else begin
            acc_r[ch] <= sat_add(acc_r[ch], step[ch]);
          end
        end
      end
      vld_p3 <= win_end;
      if (bus.enable)
        timer <= win_end ? '0 : timer + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign bus.position[g*POS_W +: POS_W] = pos_r[g];
    assign bus.velocity[g*VEL_W +: VEL_W] = vel_r[g];
  end
  assign bus.vel_valid = vld_p3;
  assign bus.direction = dir_r;
  assign bus.idx_seen  = seen_r;
  assign bus.err       = err_r;
endmodule
